// File: rtl/div_pkg.sv
// Shared defines for the execute-stage divider: word types, FSM encodings and handshake levels.
// Also provides the absolute-value helper used when DIV_SIGNED_EN is defined.
package div_pkg;

   typedef logic [31:0] RegBus;
   typedef logic [63:0] DoubleRegBus;
   typedef logic [1:0]  div_state_t;

   localparam RegBus ZeroWord = 32'h0000_0000;

   localparam logic [1:0] DivFree   = 2'b00;
   localparam logic [1:0] DivByZero = 2'b01;
   localparam logic [1:0] DivOn     = 2'b10;
   localparam logic [1:0] DivEnd    = 2'b11;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

   // Magnitude of a word; only negative signed operands are converted
   function automatic RegBus abs_word(input logic is_signed, input RegBus x);
      return (is_signed && x[31]) ? RegBus'(-x) : x;
   endfunction

endpackage

// File: rtl/div_if.sv
// Execute-to-divider handshake: operands and request from execute, result and ready back.
// The master side is the execute logic, the slave side is the divider.
interface div_if;
   import div_pkg::*;

   logic        signed_div_i;
   RegBus       opdata1_i;
   RegBus       opdata2_i;
   logic        start_i;
   logic        annul_i;
   DoubleRegBus result_o;
   logic        ready_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o
   );
endinterface

// File: rtl/div.sv
// Multi-cycle 32-bit restoring divider producing {remainder, quotient} for the HI/LO path.
// Macro DIV_SIGNED_EN adds the signed (DIV) path; without it every division is unsigned.
module div
   import div_pkg::*;
(
   input  logic clk,
   input  logic rst,
   div_if.slave bus
);

   div_state_t  state;
   logic [5:0]  cnt;
   logic [64:0] dividend;
   RegBus       divisor;
   logic [32:0] diff;
   RegBus       op1_abs;
   RegBus       op2_abs;
   RegBus       quo_final;
   RegBus       rem_final;
   logic        ready_q;
   DoubleRegBus result_q;
`ifdef DIV_SIGNED_EN
   logic        neg_quo;
   logic        neg_rem;
`endif

   // dividend[63:32] is the running partial remainder; a borrow in diff means "shift only"
   always_comb begin
      diff = {1'b0, dividend[63:32]} - {1'b0, divisor};
`ifdef DIV_SIGNED_EN
      op1_abs   = abs_word(bus.signed_div_i, bus.opdata1_i);
      op2_abs   = abs_word(bus.signed_div_i, bus.opdata2_i);
      quo_final = neg_quo ? RegBus'(-dividend[31:0])  : dividend[31:0];
      rem_final = neg_rem ? RegBus'(-dividend[64:33]) : dividend[64:33];
`else
      op1_abs   = bus.opdata1_i;
      op2_abs   = bus.opdata2_i;
      quo_final = dividend[31:0];
      rem_final = dividend[64:33];
`endif
   end

   // Sign corrections are captured at start so later operand changes cannot disturb the result
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= DivFree;
         cnt      <= '0;
         dividend <= '0;
         divisor  <= ZeroWord;
         ready_q  <= DivResultNotReady;
         result_q <= '0;
`ifdef DIV_SIGNED_EN
         neg_quo  <= 1'b0;
         neg_rem  <= 1'b0;
`endif
      end else begin
         case (state)
            DivFree: begin
               if (bus.start_i == DivStart && !bus.annul_i) begin
                  if (bus.opdata2_i == ZeroWord) begin
                     state <= DivByZero;
                  end else begin
                     state    <= DivOn;
                     cnt      <= '0;
                     dividend <= {32'b0, op1_abs, 1'b0};
                     divisor  <= op2_abs;
`ifdef DIV_SIGNED_EN
                     neg_quo  <= bus.signed_div_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
                     neg_rem  <= bus.signed_div_i & bus.opdata1_i[31];
`endif
                  end
               end
            end
            DivByZero: begin
               dividend <= '0;
               result_q <= '0;
               ready_q  <= DivResultReady;
               state    <= DivEnd;
            end
            DivOn: begin
               if (bus.annul_i) begin
                  state <= DivFree;
                  cnt   <= '0;
               end else if (cnt != 6'd32) begin
                  if (diff[32])
                     dividend <= {dividend[63:0], 1'b0};
                  else
                     dividend <= {diff[31:0], dividend[31:0], 1'b1};
                  cnt <= cnt + 6'd1;
               end else begin
                  result_q <= {rem_final, quo_final};
                  ready_q  <= DivResultReady;
                  state    <= DivEnd;
                  cnt      <= '0;
               end
            end
            DivEnd: begin
               if (bus.start_i == DivStop) begin
                  state    <= DivFree;
                  ready_q  <= DivResultNotReady;
                  result_q <= '0;
               end
            end
            default: state <= DivFree;
         endcase
      end
   end

   assign bus.ready_o  = ready_q;
   assign bus.result_o = result_q;

endmodule

// File: tb/tb_div.sv
// Directed testbench for the divider: vector table plus annul, reset and hold sequences.
// Expected values for signed vectors follow whether DIV_SIGNED_EN is defined.
module tb_div;

`ifdef DIV_SIGNED_EN
   localparam bit SignedBuild = 1'b1;
`else
   localparam bit SignedBuild = 1'b0;
`endif

   logic clk;
   logic rst;
   int   total;
   int   bad;

   div_if bus();

   div dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] expected;
      int          lat;
   } vec_t;

   vec_t vecs[12];

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.signed_div_i = sgn;
      bus.opdata1_i    = a;
      bus.opdata2_i    = b;
      bus.start_i      = 1'b1;
   endtask

   // Counts rising edges from the one that samples start until ready is seen, bounded
   task automatic wait_ready(output int cycles);
      cycles = 0;
      do begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
      end while (bus.ready_o !== 1'b1 && cycles < 100);
   endtask

   task automatic drop_start(input string name);
      @(negedge clk);
      bus.start_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput({name, "_ready_drop"}, {63'b0, bus.ready_o}, 64'd0);
      checkOutput({name, "_result_drop"}, bus.result_o, 64'd0);
   endtask

   initial begin
      int cycles;
      total = 0;
      bad   = 0;

      vecs[0]  = '{1'b0, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E}, 34};
      vecs[1]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002,
                   SignedBuild ? 64'hFFFF_FFFF_FFFF_FFFD : 64'h0000_0001_7FFF_FFFC, 34};
      vecs[2]  = '{1'b0, 32'h1234_5678, 32'h0, 64'h0, 2};
      vecs[3]  = '{1'b1, 32'h1234_5678, 32'h0, 64'h0, 2};
      vecs[4]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                   SignedBuild ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000, 34};
      vecs[5]  = '{1'b0, 32'hFFFF_FFFF, 32'h1, 64'h0000_0000_FFFF_FFFF, 34};
      vecs[6]  = '{1'b1, 32'd100, 32'hFFFF_FFF9,
                   SignedBuild ? 64'h0000_0002_FFFF_FFF2 : 64'h0000_0064_0000_0000, 34};
      vecs[7]  = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
                   SignedBuild ? 64'hFFFF_FFFE_0000_000E : 64'hFFFF_FF9C_0000_0000, 34};
      vecs[8]  = '{1'b0, 32'hDEAD_BEEF, 32'h10, 64'h0000_000F_0DEA_DBEE, 34};
      vecs[9]  = '{1'b0, 32'd5, 32'd9, 64'h0000_0005_0000_0000, 34};
      vecs[10] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 64'h0000_0000_0000_0001, 34};
      vecs[11] = '{1'b0, 32'd1000000, 32'd1000, 64'h0000_0000_0000_03E8, 34};

      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = '0;
      bus.opdata2_i    = '0;
      bus.start_i      = 1'b0;
      bus.annul_i      = 1'b0;
      rst              = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_ready", {63'b0, bus.ready_o}, 64'd0);
      checkOutput("reset_result", bus.result_o, 64'd0);
      rst = 1'b1;

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b);
         wait_ready(cycles);
         checkOutput($sformatf("v%0d_latency", i), 64'(cycles), 64'(vecs[i].lat));
         checkOutput($sformatf("v%0d_result", i), bus.result_o, vecs[i].expected);
         drop_start($sformatf("v%0d", i));
      end

      // Flush at E10, then a fresh request sampled at E12
      applyStimulus(1'b0, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      @(negedge clk);
      bus.annul_i = 1'b1;
      bus.start_i = 1'b0;
      @(negedge clk);
      bus.annul_i = 1'b0;
      checkOutput("annul_ready", {63'b0, bus.ready_o}, 64'd0);
      applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h1);
      wait_ready(cycles);
      checkOutput("annul_restart_latency", 64'(cycles), 64'd34);
      checkOutput("annul_restart_result", bus.result_o, 64'h0000_0000_FFFF_FFFF);
      drop_start("annul_restart");

      // Start and annul together in DivFree must not launch a division
      applyStimulus(1'b0, 32'd100, 32'd7);
      bus.annul_i = 1'b1;
      repeat (3) @(negedge clk);
      bus.annul_i = 1'b0;
      wait_ready(cycles);
      checkOutput("annul_start_latency", 64'(cycles), 64'd34);
      checkOutput("annul_start_result", bus.result_o, {32'h2, 32'hE});
      drop_start("annul_start");

      // Asynchronous reset mid-DivOn, then a clean division afterwards
      applyStimulus(1'b0, 32'hDEAD_BEEF, 32'h10);
      repeat (10) @(posedge clk);
      #2;
      rst         = 1'b0;
      bus.start_i = 1'b0;
      #1;
      checkOutput("rst_on_ready", {63'b0, bus.ready_o}, 64'd0);
      checkOutput("rst_on_result", bus.result_o, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(1'b0, 32'd1000000, 32'd1000);
      wait_ready(cycles);
      checkOutput("rst_after_latency", 64'(cycles), 64'd34);
      checkOutput("rst_after_result", bus.result_o, 64'h3E8);
      drop_start("rst_after");

      // Operands change after start, result held through five DivEnd cycles
      applyStimulus(1'b0, 32'd1000, 32'd3);
      @(negedge clk);
      bus.signed_div_i = 1'b1;
      bus.opdata1_i    = 32'hFFFF_FFFF;
      bus.opdata2_i    = 32'h0;
      wait_ready(cycles);
      checkOutput("hold_latency", 64'(cycles + 1), 64'd34);
      for (int k = 0; k < 5; k++) begin
         checkOutput($sformatf("hold%0d_ready", k), {63'b0, bus.ready_o}, 64'd1);
         checkOutput($sformatf("hold%0d_result", k), bus.result_o, {32'h1, 32'h14D});
         @(negedge clk);
      end

      // Reset while the result is presented clears outputs without a clock edge
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("rst_end_ready", {63'b0, bus.ready_o}, 64'd0);
      checkOutput("rst_end_result", bus.result_o, 64'd0);
      bus.start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/div.md
# div

- Multi-cycle 32-bit integer divider in the execute stage.
- Consumes the operand pair and DIV/DIVU operation delivered by the decode-to-execute pipeline register.
- Produces a 64-bit {remainder, quotient} for the HI/LO write path.
- Execute logic holds the pipeline stalled while the divider is busy and aborts it on flush.

## Interface
Parameters: none; all widths come from shared defines.

Reset is asynchronous and active-low. All other signals are sampled on the rising edge of `clk`.

- `clk`  input  1  pipeline clock
- `rst`  input  1  asynchronous active-low reset
- `signed_div_i`  input  1  1 = signed (DIV), 0 = unsigned (DIVU)
- `opdata1_i`  input  32  dividend
- `opdata2_i`  input  32  divisor
- `start_i`  input  1  request; held high by execute logic until `ready_o` is seen
- `annul_i`  input  1  abort the current division (pipeline flush)
- `result_o`  output  64  {remainder[63:32], quotient[31:0]}
- `ready_o`  output  1  result valid

## Operation
State machine states, 2-bit: DivFree, DivByZero, DivOn, DivEnd. Internal state:
- 65-bit working register `dividend`
- 6-bit counter `cnt`
- latched divisor

Transitions:
- **DivFree**
  - If `start_i`=1 and `annul_i`=0:
    - divisor == 0 → DivByZero.
    - Otherwise → DivOn, cnt←0, dividend←{32'b0, |op1|, 1'b0}, divisor←|op2|.
  - |x| is applied only for signed operations with x[31]=1; unsigned operands pass through.
  - Otherwise stay in DivFree.
- **DivByZero**: dividend←0 → DivEnd.
- **DivOn**
  - `annul_i`=1 → DivFree, cnt←0.
  - cnt≠32: iteration step (below), then cnt←cnt+1.
  - cnt==32: apply sign fix-up, result←{dividend[64:33], dividend[31:0]}, → DivEnd, cnt←0.
- **DivEnd**
  - `ready_o`=1 and `result_o` held constant.
  - `start_i`=0 → DivFree; `ready_o`←0 and `result_o`←0 on that edge.

Iteration step:
- diff = {1'b0, dividend[63:32]} − {1'b0, divisor}, 33 bits.
- diff[32]=1 → dividend←{dividend[63:0], 1'b0}.
- Otherwise → dividend←{diff[31:0], dividend[31:0], 1'b1}.

Sign fix-up (signed only):
- Quotient is negated when op1[31] ^ op2[31].
- Remainder is negated when op1[31]; it takes the sign of the dividend.
- Operands are latched at start; later changes on `opdata*_i` are ignored.

Boundary conditions:
- 0x80000000 / 0xFFFFFFFF signed: quotient 0x80000000, remainder 0 (two's-complement wrap, no trap).
- Divide by zero: result 0 for both signed and unsigned.
- `start_i` in DivOn or DivByZero is ignored.
- `annul_i` in DivFree, DivByZero or DivEnd has no effect.
- `annul_i` and `start_i` both high in DivFree: start is not taken.

## Timing
- Reset, asynchronous: state DivFree, cnt 0, `ready_o` 0, `result_o` 64'b0, internal registers 0.
- Edge numbering: E1 is the edge that samples `start_i`.
  - Normal path: E2–E33 perform 32 iterations, E34 finalizes, `ready_o` high in the cycle after E34. Latency is 34 cycles.
  - Divide by zero: `ready_o` high after E2.
- `ready_o` stays high as long as `start_i` stays high.
- Back-to-back divisions need at least one cycle with `start_i` low.
- Reset asserted mid-operation clears everything immediately; no partial result is exposed.

## Configuration
Macro `DIV_SIGNED_EN`:
- **Defined**: signed path included (absolute-value conversion and sign fix-up).
- **Undefined**: `signed_div_i` is ignored and every division is unsigned. The abs/negate logic is not synthesized.

## Structure
Shared defines file gets:
- State encodings: DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11.
- DivResultReady/DivResultNotReady, DivStart/DivStop.
- Existing ZeroWord and RegBus are reused.

Single module, no sub-module; the subtract/shift step is inline.

## Test plan
- Unsigned 100 / 7, start held → `ready_o` rises after E34; result {0x00000002, 0x0000000E}.
- Signed −7 / 2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. With `DIV_SIGNED_EN` undefined → quotient 0x7FFFFFFC, remainder 0x00000001.
- Divisor 0, dividend 0x12345678 → `ready_o` after E2, result 64'b0.
- `annul_i` pulsed at E10 → state DivFree. `ready_o` never rises. A new start at E12 for 0xFFFFFFFF / 1 unsigned → result {0, 0xFFFFFFFF}.
- Async `rst` low mid-DivOn → outputs 0 immediately. A start after release completes normally with 34-cycle latency.
- `start_i` held through DivEnd for 5 cycles → result stable and `ready_o` high. Drop start → `ready_o`/`result_o` go to 0 next edge.
